// File: rtl/dsd7_bus_arb.sv
// Two-master (instruction/data) bus arbiter in front of the MMU with a bus-error timeout.
// Define DSD7_ARB_ROUNDROBIN_EN to break request ties round-robin instead of favouring data.
module dsd7_bus_arb #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // instruction port
  input  logic        i_cyc_i,
  input  logic        i_stb_i,
  input  logic [31:0] i_adr_i,
  output logic        i_ack_o,
  output logic        i_err_o,
  output logic [31:0] i_dat_o,
  // data port
  input  logic        d_cyc_i,
  input  logic        d_stb_i,
  input  logic        d_wr_i,
  input  logic [1:0]  d_sel_i,
  input  logic [31:0] d_adr_i,
  input  logic [31:0] d_dat_i,
  input  logic        d_sr_i,
  input  logic        d_cr_i,
  output logic        d_ack_o,
  output logic        d_err_o,
  output logic [31:0] d_dat_o,
  output logic        d_rb_o,
  // MMU side
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_vpa_o,
  output logic        m_vda_o,
  output logic        m_wr_o,
  output logic [1:0]  m_sel_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  output logic        m_sr_o,
  output logic        m_cr_o,
  input  logic        m_ack_i,
  input  logic [31:0] m_dat_i,
  input  logic        m_rb_i
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StGrantI   = 3'd1;
  localparam logic [2:0] StGrantD   = 3'd2;
  localparam logic [2:0] StWaitNack = 3'd3;
  localparam logic [2:0] StWaitMack = 3'd4;

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  logic [2:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  // Granted port (1 = data); it also serves as the last-grant flag for round-robin ties.
  logic        sel_d_q, sel_d_d;

  logic        i_ack_q, i_ack_d, i_err_q, i_err_d;
  logic [31:0] i_dat_q, i_dat_d;
  logic        d_ack_q, d_ack_d, d_err_q, d_err_d, d_rb_q, d_rb_d;
  logic [31:0] d_dat_q, d_dat_d;
  logic        m_cyc_q, m_cyc_d, m_stb_q, m_stb_d, m_vpa_q, m_vpa_d, m_vda_q, m_vda_d;
  logic        m_wr_q, m_wr_d, m_sr_q, m_sr_d, m_cr_q, m_cr_d;
  logic [1:0]  m_sel_q, m_sel_d;
  logic [31:0] m_adr_q, m_adr_d, m_dat_q, m_dat_d;

  logic i_req, d_req, g_cyc, g_stb, tie_to_d, port_busy;

  assign i_req     = i_cyc_i & i_stb_i;
  assign d_req     = d_cyc_i & d_stb_i;
  assign g_cyc     = sel_d_q ? d_cyc_i : i_cyc_i;
  assign g_stb     = sel_d_q ? d_stb_i : i_stb_i;
  assign port_busy = i_ack_q | i_err_q | d_ack_q | d_err_q;

`ifdef DSD7_ARB_ROUNDROBIN_EN
  assign tie_to_d = ~sel_d_q;
`else
  assign tie_to_d = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d_d = sel_d_q;
    i_ack_d = i_ack_q;
    i_err_d = i_err_q;
    i_dat_d = i_dat_q;
    d_ack_d = d_ack_q;
    d_err_d = d_err_q;
    d_dat_d = d_dat_q;
    d_rb_d  = d_rb_q;
    m_cyc_d = m_cyc_q;
    m_stb_d = m_stb_q;
    m_vpa_d = m_vpa_q;
    m_vda_d = m_vda_q;
    m_wr_d  = m_wr_q;
    m_sel_d = m_sel_q;
    m_adr_d = m_adr_q;
    m_dat_d = m_dat_q;
    m_sr_d  = m_sr_q;
    m_cr_d  = m_cr_q;

    unique case (state_q)
      StIdle: begin
        if (d_req && (!i_req || tie_to_d)) begin
          sel_d_d = 1'b1;
          cnt_d   = 8'd0;
          state_d = StGrantD;
        end else if (i_req) begin
          sel_d_d = 1'b0;
          cnt_d   = 8'd0;
          state_d = StGrantI;
        end
      end

      StGrantI, StGrantD: begin
        if (!g_cyc) begin
          {m_cyc_d, m_stb_d, m_vpa_d, m_vda_d, m_wr_d, m_sr_d, m_cr_d} = '0;
          m_sel_d = '0;
          m_adr_d = '0;
          m_dat_d = '0;
          state_d = StWaitMack;
        end else if (m_stb_q && m_ack_i) begin
          // Ack takes precedence over a timeout reached in the same cycle.
          if (sel_d_q) begin
            d_ack_d = 1'b1;
            d_dat_d = m_dat_i;
            d_rb_d  = m_rb_i;
          end else begin
            i_ack_d = 1'b1;
            i_dat_d = m_dat_i;
          end
          m_stb_d = 1'b0;
          state_d = StWaitNack;
        end else if (cnt_q == TimeoutCnt) begin
          if (sel_d_q) d_err_d = 1'b1;
          else         i_err_d = 1'b1;
          m_cyc_d = 1'b0;
          m_stb_d = 1'b0;
          state_d = StWaitNack;
        end else begin
          cnt_d   = cnt_q + 8'd1;
          m_cyc_d = 1'b1;
          m_stb_d = 1'b1;
          if (sel_d_q) begin
            m_vpa_d = 1'b0;
            m_vda_d = 1'b1;
            m_wr_d  = d_wr_i;
            m_sel_d = d_sel_i;
            m_adr_d = d_adr_i;
            m_dat_d = d_dat_i;
            m_sr_d  = d_sr_i;
            m_cr_d  = d_cr_i;
          end else begin
            m_vpa_d = 1'b1;
            m_vda_d = 1'b0;
            m_wr_d  = 1'b0;
            m_sel_d = 2'b11;
            m_adr_d = i_adr_i;
            m_dat_d = '0;
            m_sr_d  = 1'b0;
            m_cr_d  = 1'b0;
          end
        end
      end

      StWaitNack: begin
        if (!g_cyc) begin
          {m_cyc_d, m_stb_d, m_vpa_d, m_vda_d, m_wr_d, m_sr_d, m_cr_d} = '0;
          m_sel_d = '0;
          m_adr_d = '0;
          m_dat_d = '0;
          {i_ack_d, i_err_d, d_ack_d, d_err_d} = '0;
          i_dat_d = '0;
          d_dat_d = '0;
          state_d = StWaitMack;
        end else if (!g_stb) begin
          {i_ack_d, i_err_d, d_ack_d, d_err_d} = '0;
          i_dat_d = '0;
          d_dat_d = '0;
        end else if (!port_busy) begin
          // Strobe re-raised under a held cycle: bus stays locked to the same master.
          cnt_d   = 8'd0;
          state_d = sel_d_q ? StGrantD : StGrantI;
        end
      end

      StWaitMack: begin
        if (!m_ack_i) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sel_d_q <= 1'b0;
      i_ack_q <= 1'b0;
      i_err_q <= 1'b0;
      i_dat_q <= '0;
      d_ack_q <= 1'b0;
      d_err_q <= 1'b0;
      d_dat_q <= '0;
      d_rb_q  <= 1'b0;
      m_cyc_q <= 1'b0;
      m_stb_q <= 1'b0;
      m_vpa_q <= 1'b0;
      m_vda_q <= 1'b0;
      m_wr_q  <= 1'b0;
      m_sel_q <= '0;
      m_adr_q <= '0;
      m_dat_q <= '0;
      m_sr_q  <= 1'b0;
      m_cr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_d_q <= sel_d_d;
      i_ack_q <= i_ack_d;
      i_err_q <= i_err_d;
      i_dat_q <= i_dat_d;
      d_ack_q <= d_ack_d;
      d_err_q <= d_err_d;
      d_dat_q <= d_dat_d;
      d_rb_q  <= d_rb_d;
      m_cyc_q <= m_cyc_d;
      m_stb_q <= m_stb_d;
      m_vpa_q <= m_vpa_d;
      m_vda_q <= m_vda_d;
      m_wr_q  <= m_wr_d;
      m_sel_q <= m_sel_d;
      m_adr_q <= m_adr_d;
      m_dat_q <= m_dat_d;
      m_sr_q  <= m_sr_d;
      m_cr_q  <= m_cr_d;
    end
  end

  assign i_ack_o = i_ack_q;
  assign i_err_o = i_err_q;
  assign i_dat_o = i_dat_q;
  assign d_ack_o = d_ack_q;
  assign d_err_o = d_err_q;
  assign d_dat_o = d_dat_q;
  assign d_rb_o  = d_rb_q;
  assign m_cyc_o = m_cyc_q;
  assign m_stb_o = m_stb_q;
  assign m_vpa_o = m_vpa_q;
  assign m_vda_o = m_vda_q;
  assign m_wr_o  = m_wr_q;
  assign m_sel_o = m_sel_q;
  assign m_adr_o = m_adr_q;
  assign m_dat_o = m_dat_q;
  assign m_sr_o  = m_sr_q;
  assign m_cr_o  = m_cr_q;

endmodule

// File: tb/tb_dsd7_bus_arb.sv
// Directed bench for dsd7_bus_arb: fetch, priority, locked RMW, abort, timeout and reset.
module tb_dsd7_bus_arb;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        i_cyc_i, i_stb_i;
  logic [31:0] i_adr_i;
  logic        i_ack_o, i_err_o;
  logic [31:0] i_dat_o;
  logic        d_cyc_i, d_stb_i, d_wr_i, d_sr_i, d_cr_i;
  logic [1:0]  d_sel_i;
  logic [31:0] d_adr_i, d_dat_i;
  logic        d_ack_o, d_err_o, d_rb_o;
  logic [31:0] d_dat_o;
  logic        m_cyc_o, m_stb_o, m_vpa_o, m_vda_o, m_wr_o, m_sr_o, m_cr_o;
  logic [1:0]  m_sel_o;
  logic [31:0] m_adr_o, m_dat_o;
  logic        m_ack_i, m_rb_i;
  logic [31:0] m_dat_i;

  int n_cmp = 0;
  int n_err = 0;
  logic [2:0] exp_d;

  always #5 clk_i = ~clk_i;

  dsd7_bus_arb #(.TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .i_cyc_i(i_cyc_i), .i_stb_i(i_stb_i), .i_adr_i(i_adr_i),
    .i_ack_o(i_ack_o), .i_err_o(i_err_o), .i_dat_o(i_dat_o),
    .d_cyc_i(d_cyc_i), .d_stb_i(d_stb_i), .d_wr_i(d_wr_i), .d_sel_i(d_sel_i),
    .d_adr_i(d_adr_i), .d_dat_i(d_dat_i), .d_sr_i(d_sr_i), .d_cr_i(d_cr_i),
    .d_ack_o(d_ack_o), .d_err_o(d_err_o), .d_dat_o(d_dat_o), .d_rb_o(d_rb_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_vpa_o(m_vpa_o), .m_vda_o(m_vda_o),
    .m_wr_o(m_wr_o), .m_sel_o(m_sel_o), .m_adr_o(m_adr_o), .m_dat_o(m_dat_o),
    .m_sr_o(m_sr_o), .m_cr_o(m_cr_o),
    .m_ack_i(m_ack_i), .m_dat_i(m_dat_i), .m_rb_i(m_rb_i)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni  = 1'b0;
    {i_cyc_i, i_stb_i, d_cyc_i, d_stb_i, d_wr_i, d_sr_i, d_cr_i, m_ack_i, m_rb_i} = '0;
    i_adr_i = '0; d_adr_i = '0; d_dat_i = '0; d_sel_i = '0; m_dat_i = '0;

    // Reset state, with a request pending to show reset dominates.
    d_cyc_i = 1'b1; d_stb_i = 1'b1;
    step(); step();
    chk1("rst_m_cyc", m_cyc_o, 1'b0);
    chk1("rst_d_ack", d_ack_o, 1'b0);
    chk32("rst_m_adr", m_adr_o, 32'h0);
    d_cyc_i = 1'b0; d_stb_i = 1'b0;
    rst_ni = 1'b1;

    // Instruction fetch, MMU acks after two strobe cycles.
    i_cyc_i = 1'b1; i_stb_i = 1'b1; i_adr_i = 32'h0000_1000;
    step();
    chk1("if_m_cyc_grant_edge", m_cyc_o, 1'b0);
    step();
    chk1("if_m_cyc", m_cyc_o, 1'b1);
    chk1("if_m_stb", m_stb_o, 1'b1);
    chk1("if_vpa", m_vpa_o, 1'b1);
    chk1("if_vda", m_vda_o, 1'b0);
    chk32("if_adr", m_adr_o, 32'h0000_1000);
    chk32("if_sel", {30'b0, m_sel_o}, 32'h3);
    step();
    chk1("if_no_ack_yet", i_ack_o, 1'b0);
    m_ack_i = 1'b1; m_dat_i = 32'hDEAD_BEEF;
    step();
    chk1("if_i_ack", i_ack_o, 1'b1);
    chk32("if_i_dat", i_dat_o, 32'hDEAD_BEEF);
    chk1("if_d_ack", d_ack_o, 1'b0);
    chk1("if_m_stb_clr", m_stb_o, 1'b0);
    m_ack_i = 1'b0; i_cyc_i = 1'b0; i_stb_i = 1'b0;
    step();
    chk1("if_end_m_cyc", m_cyc_o, 1'b0);
    chk1("if_end_i_ack", i_ack_o, 1'b0);
    chk32("if_end_i_dat", i_dat_o, 32'h0);
    step();

    // Simultaneous requests: data first, instruction after cyc drop and m_ack low.
    i_cyc_i = 1'b1; i_stb_i = 1'b1; i_adr_i = 32'h0000_2000;
    d_cyc_i = 1'b1; d_stb_i = 1'b1; d_adr_i = 32'h0000_3000; d_dat_i = 32'h1234_5678;
    d_wr_i = 1'b1; d_sel_i = 2'b01;
    step(); step();
    chk1("tie_vda", m_vda_o, 1'b1);
    chk1("tie_vpa", m_vpa_o, 1'b0);
    chk1("tie_wr", m_wr_o, 1'b1);
    chk32("tie_sel", {30'b0, m_sel_o}, 32'h1);
    chk32("tie_adr", m_adr_o, 32'h0000_3000);
    chk32("tie_wdat", m_dat_o, 32'h1234_5678);
    m_ack_i = 1'b1; m_dat_i = 32'hCAFE_0001;
    step();
    chk1("tie_d_ack", d_ack_o, 1'b1);
    chk32("tie_d_dat", d_dat_o, 32'hCAFE_0001);
    chk1("tie_i_ack", i_ack_o, 1'b0);
    chk1("tie_i_err", i_err_o, 1'b0);
    d_cyc_i = 1'b0; d_stb_i = 1'b0; d_wr_i = 1'b0;
    step();
    chk1("tie_drop_m_cyc", m_cyc_o, 1'b0);
    step();
    chk1("tie_mack_hold", m_cyc_o, 1'b0);
    m_ack_i = 1'b0;
    step(); step();
    chk1("tie_i_wait", m_cyc_o, 1'b0);
    step();
    chk1("tie_i_vpa", m_vpa_o, 1'b1);
    chk32("tie_i_adr", m_adr_o, 32'h0000_2000);
    m_ack_i = 1'b1; m_dat_i = 32'h0BAD_F00D;
    step();
    chk1("tie_i_ack2", i_ack_o, 1'b1);
    i_cyc_i = 1'b0; i_stb_i = 1'b0; m_ack_i = 1'b0;
    step(); step();

    // Three back-to-back tie pairs; last grant is instruction here.
`ifdef DSD7_ARB_ROUNDROBIN_EN
    exp_d = 3'b101;
`else
    exp_d = 3'b111;
`endif
    for (int r = 0; r < 3; r++) begin
      i_cyc_i = 1'b1; i_stb_i = 1'b1; d_cyc_i = 1'b1; d_stb_i = 1'b1;
      step(); step();
      chk1($sformatf("pair%0d_vda", r), m_vda_o, exp_d[r]);
      m_ack_i = 1'b1; m_dat_i = 32'hA000_0000 + 32'(r);
      step();
      chk1($sformatf("pair%0d_d_ack", r), d_ack_o, exp_d[r]);
      chk1($sformatf("pair%0d_i_ack", r), i_ack_o, ~exp_d[r]);
      {i_cyc_i, i_stb_i, d_cyc_i, d_stb_i, m_ack_i} = '0;
      step(); step();
    end

    // Locked sr read then cr write with instruction requesting throughout.
    d_cyc_i = 1'b1; d_stb_i = 1'b1; d_sr_i = 1'b1; d_sel_i = 2'b11; d_adr_i = 32'h0000_5000;
    step();
    i_cyc_i = 1'b1; i_stb_i = 1'b1; i_adr_i = 32'h0000_4000;
    step();
    chk1("rmw_sr", m_sr_o, 1'b1);
    chk1("rmw_vda", m_vda_o, 1'b1);
    m_ack_i = 1'b1; m_dat_i = 32'h0000_0055; m_rb_i = 1'b0;
    step();
    chk32("rmw_rd_dat", d_dat_o, 32'h0000_0055);
    m_ack_i = 1'b0; d_stb_i = 1'b0;
    step();
    chk1("rmw_nack_clr", d_ack_o, 1'b0);
    chk1("rmw_cyc_a", m_cyc_o, 1'b1);
    d_stb_i = 1'b1; d_wr_i = 1'b1; d_sr_i = 1'b0; d_cr_i = 1'b1; d_dat_i = 32'h0000_00AA;
    step();
    chk1("rmw_cyc_b", m_cyc_o, 1'b1);
    step();
    chk1("rmw_cyc_c", m_cyc_o, 1'b1);
    chk1("rmw_cr", m_cr_o, 1'b1);
    chk1("rmw_vpa", m_vpa_o, 1'b0);
    chk32("rmw_wdat", m_dat_o, 32'h0000_00AA);
    m_ack_i = 1'b1; m_rb_i = 1'b1;
    step();
    chk1("rmw_rb", d_rb_o, 1'b1);
    chk1("rmw_cyc_d", m_cyc_o, 1'b1);
    chk1("rmw_i_ack", i_ack_o, 1'b0);
    {d_cyc_i, d_stb_i, d_wr_i, d_cr_i, m_ack_i, m_rb_i} = '0;
    step();
    chk1("rmw_end_cyc", m_cyc_o, 1'b0);
    step(); step(); step();
    chk1("rmw_then_i", m_vpa_o, 1'b1);

    // Instruction abort while granted: no ack, bus released.
    i_cyc_i = 1'b0; i_stb_i = 1'b0;
    step();
    chk1("abort_m_cyc", m_cyc_o, 1'b0);
    chk1("abort_i_ack", i_ack_o, 1'b0);
    step();

    // Timeout with TIMEOUT=4: error after the fifth grant cycle.
    d_cyc_i = 1'b1; d_stb_i = 1'b1; d_adr_i = 32'h0000_6000;
    step(); step();
    chk1("to_m_cyc", m_cyc_o, 1'b1);
    step(); step(); step();
    chk1("to_no_err_yet", d_err_o, 1'b0);
    step();
    chk1("to_d_err", d_err_o, 1'b1);
    chk1("to_d_ack", d_ack_o, 1'b0);
    chk1("to_m_cyc_clr", m_cyc_o, 1'b0);
    chk1("to_m_stb_clr", m_stb_o, 1'b0);
    d_cyc_i = 1'b0; d_stb_i = 1'b0;
    step();
    chk1("to_err_clr", d_err_o, 1'b0);
    step();

    // Asynchronous reset in the middle of an acked data cycle.
    d_cyc_i = 1'b1; d_stb_i = 1'b1;
    step(); step();
    m_ack_i = 1'b1; m_dat_i = 32'hFFFF_FFFF;
    step();
    chk1("ar_pre_ack", d_ack_o, 1'b1);
    #2 rst_ni = 1'b0;
    #1;
    chk1("ar_m_cyc", m_cyc_o, 1'b0);
    chk1("ar_d_ack", d_ack_o, 1'b0);
    chk32("ar_d_dat", d_dat_o, 32'h0);
    chk32("ar_m_adr", m_adr_o, 32'h0);
    {d_cyc_i, d_stb_i, m_ack_i} = '0;
    step();
    i_cyc_i = 1'b1; i_stb_i = 1'b1;
    rst_ni = 1'b1;
    step(); step();
    chk1("post_rst_grant", m_vpa_o, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
